hist_job_scheduler: RTL

HIST_JOB_SCHEDULER -- requirements
Module: hist_job_scheduler

---
 rtl/hist_pkg.sv | 21 ++
 rtl/hist_job_scheduler_rr_arbiter.sv | 33 +++
 rtl/hist_job_scheduler.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/hist_pkg.sv
// Shared types and size derivations for the histogram job scheduler.
package hist_pkg;

    localparam int DEF_NUM_REQ       = 4;
    localparam int DEF_STREAM_LENGTH = 128;
    localparam int DEF_DONE_TIMEOUT  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FEED   = 3'd2,
        DRAIN  = 3'd3,
        RESULT = 3'd4
    } state_e;

    // Counter must hold the full STREAM_LENGTH value, not just STREAM_LENGTH-1.
    function automatic int cnt_width(input int stream_length);
        return $clog2(stream_length + 1);
    endfunction

endpackage

// File: rtl/hist_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: first set request at or above ptr_i, wrapping around.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    // Scan from the farthest candidate down so the closest request to ptr_i wins last.
    always_comb begin
        logic [IDX_W-1:0] cand;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = IDX_W'((int'(ptr_i) + off) % NUM_REQ);
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                any_o       = 1'b1;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/hist_job_scheduler.sv
// Time-shares one histogram_compressor between NUM_REQ requesters, one job
// (STREAM_LENGTH bit pairs) at a time, and returns the four counts per job.
module hist_job_scheduler
    import hist_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int STREAM_LENGTH = DEF_STREAM_LENGTH,
    parameter int COUNTER_WIDTH = cnt_width(STREAM_LENGTH),
    parameter int DONE_TIMEOUT  = DEF_DONE_TIMEOUT,
    localparam int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    output logic [NUM_REQ-1:0]       gnt,
    input  logic [NUM_REQ-1:0]       src_a,
    input  logic [NUM_REQ-1:0]       src_b,
    input  logic [NUM_REQ-1:0]       src_valid,
    output logic [NUM_REQ-1:0]       src_ready,
    output logic                     core_rst_n,
    output logic                     core_stream_a,
    output logic                     core_stream_b,
    output logic                     core_valid,
    input  logic [COUNTER_WIDTH-1:0] core_count_00,
    input  logic [COUNTER_WIDTH-1:0] core_count_01,
    input  logic [COUNTER_WIDTH-1:0] core_count_10,
    input  logic [COUNTER_WIDTH-1:0] core_count_11,
    input  logic                     core_done,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [IDX_W-1:0]         res_id,
    output logic [COUNTER_WIDTH-1:0] res_count_00,
    output logic [COUNTER_WIDTH-1:0] res_count_01,
    output logic [COUNTER_WIDTH-1:0] res_count_10,
    output logic [COUNTER_WIDTH-1:0] res_count_11,
    output logic                     res_timeout
);

    localparam int WAIT_W = $clog2(DONE_TIMEOUT + 1);
    localparam logic [COUNTER_WIDTH-1:0] LAST_PAIR = COUNTER_WIDTH'(STREAM_LENGTH - 1);

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         win_q, win_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [COUNTER_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic [WAIT_W-1:0]        wait_cnt_q, wait_cnt_d;
    logic [NUM_REQ-1:0]       gnt_q, gnt_d;
    logic                     core_rst_n_q;
    logic                     res_valid_q;
    logic [IDX_W-1:0]         res_id_q;
    logic [COUNTER_WIDTH-1:0] res_c00_q, res_c01_q, res_c10_q, res_c11_q;
    logic                     res_timeout_q;

    logic [NUM_REQ-1:0]       arb_gnt_s;
    logic [IDX_W-1:0]         arb_idx_s;
    logic                     arb_any_s;
    logic                     feed_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt_s),
        .idx_o (arb_idx_s),
        .any_o (arb_any_s)
    );

    assign feed_s = (state_q == FEED);

    // Winner's stream is passed straight through to the core while feeding.
    always_comb begin
        src_ready     = '0;
        core_valid    = 1'b0;
        core_stream_a = 1'b0;
        core_stream_b = 1'b0;
        if (feed_s) begin
            src_ready[win_q] = 1'b1;
            core_valid       = src_valid[win_q];
            core_stream_a    = src_a[win_q];
            core_stream_b    = src_b[win_q];
        end else begin
            src_ready = '0;
        end
    end

    // Next-state logic; wait_cnt_q times both the CLEAR pulse and the DRAIN timeout.
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        rr_ptr_d   = rr_ptr_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        gnt_d      = gnt_q;
        case (state_q)
            IDLE: begin
                if (arb_any_s) begin
                    state_d    = CLEAR;
                    win_d      = arb_idx_s;
                    gnt_d      = arb_gnt_s;
                    bit_cnt_d  = '0;
                    wait_cnt_d = '0;
                end else begin
                    gnt_d = '0;
                end
            end
            CLEAR: begin
                if (wait_cnt_q == WAIT_W'(1)) begin
                    state_d    = FEED;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            FEED: begin
                if (core_valid && (bit_cnt_q == LAST_PAIR)) begin
                    state_d    = DRAIN;
                    bit_cnt_d  = '0;
                    wait_cnt_d = '0;
                end else if (core_valid) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            DRAIN: begin
                if (core_done || (wait_cnt_q == WAIT_W'(DONE_TIMEOUT - 1))) begin
                    state_d = RESULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    rr_ptr_d = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                end else begin
                    state_d = RESULT;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State, bookkeeping and registered result/core-control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            win_q         <= '0;
            rr_ptr_q      <= '0;
            bit_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            gnt_q         <= '0;
            core_rst_n_q  <= 1'b0;
            res_valid_q   <= 1'b0;
            res_id_q      <= '0;
            res_c00_q     <= '0;
            res_c01_q     <= '0;
            res_c10_q     <= '0;
            res_c11_q     <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            rr_ptr_q     <= rr_ptr_d;
            bit_cnt_q    <= bit_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            gnt_q        <= gnt_d;
            core_rst_n_q <= (state_d != CLEAR);
            res_valid_q  <= (state_d == RESULT);
            if ((state_q == DRAIN) && (state_d == RESULT)) begin
                res_id_q      <= win_q;
                res_c00_q     <= core_count_00;
                res_c01_q     <= core_count_01;
                res_c10_q     <= core_count_10;
                res_c11_q     <= core_count_11;
                res_timeout_q <= ~core_done;
            end
        end
    end

    assign gnt          = gnt_q;
    assign core_rst_n   = core_rst_n_q;
    assign res_valid    = res_valid_q;
    assign res_id       = res_id_q;
    assign res_count_00 = res_c00_q;
    assign res_count_01 = res_c01_q;
    assign res_count_10 = res_c10_q;
    assign res_count_11 = res_c11_q;
    assign res_timeout  = res_timeout_q;

endmodule
